// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//    Time-multiplexes six BCD digits (hh:mm:ss) onto one shared 7-segment bus.
//    The digits are snapshotted once per frame. Each slot starts with one dark
//    cycle to suppress ghosting. Digits can blink individually, and a zero in
//    the hour-tens position can be blanked.
//
// Ports
//    clk        : system clock, rising edge
//    clr        : synchronous reset, active-high, overrides everything
//    sec_u..hour_t : BCD digits for slots 0..5
//    blink_mask : bit i set -> digit i blinks
//    lz_blank   : blank hour tens when it reads 0
//    seg        : segments a..g on bits 0..6, active-high
//    dig_sel    : one-hot digit enable, bit i = slot i
//    frame_tick : one-cycle pulse at each frame wrap
module seg_scan_driver #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int DIV_W        = 10,
    parameter int BF_W         = 6
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] sec_u,
    input  logic [3:0] sec_t,
    input  logic [3:0] min_u,
    input  logic [3:0] min_t,
    input  logic [3:0] hour_u,
    input  logic [3:0] hour_t,
    input  logic [5:0] blink_mask,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic [5:0] dig_sel,
    output logic       frame_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic [2:0]       dig_idx_q,   dig_idx_d;
    logic [BF_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [3:0]       shadow_q [0:5];
    logic [3:0]       shadow_d [0:5];
    logic [6:0]       seg_q,       seg_d;
    logic [5:0]       dig_sel_q,   dig_sel_d;
    logic             frame_tick_q, frame_tick_d;

    logic             slot_end;
    logic             frame_wrap;
    logic [5:0]       onehot;
    logic [3:0]       cur_digit;
    logic             blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;  // invalid BCD shows a dash
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end   = (div_cnt_q == DIV_LAST);
        frame_wrap = slot_end && (dig_idx_q == 3'd5);

        div_cnt_d = slot_end ? '0 : div_cnt_q + DIV_W'(1);

        dig_idx_d = dig_idx_q;
        if (slot_end) begin
            dig_idx_d = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
        end

        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        shadow_d      = shadow_q;
        if (frame_wrap) begin
            if (frame_cnt_q == BF_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + BF_W'(1);
            end
            // Single snapshot point per frame keeps the displayed time coherent.
            shadow_d[0] = sec_u;
            shadow_d[1] = sec_t;
            shadow_d[2] = min_u;
            shadow_d[3] = min_t;
            shadow_d[4] = hour_u;
            shadow_d[5] = hour_t;
        end

        onehot    = 6'b0;
        cur_digit = 4'd0;
        case (dig_idx_q)
            3'd0: begin onehot = 6'b000001; cur_digit = shadow_q[0]; end
            3'd1: begin onehot = 6'b000010; cur_digit = shadow_q[1]; end
            3'd2: begin onehot = 6'b000100; cur_digit = shadow_q[2]; end
            3'd3: begin onehot = 6'b001000; cur_digit = shadow_q[3]; end
            3'd4: begin onehot = 6'b010000; cur_digit = shadow_q[4]; end
            3'd5: begin onehot = 6'b100000; cur_digit = shadow_q[5]; end
            default: begin onehot = 6'b0; cur_digit = 4'd0; end
        endcase

        // blink_mask and lz_blank are live, not part of the frame snapshot.
        blank = (blink_phase_q && (|(onehot & blink_mask)))
             || ((dig_idx_q == 3'd5) && lz_blank && (shadow_q[5] == 4'd0));

        seg_d        = blank ? 7'b0 : decode(cur_digit);
        // First cycle of each slot is dark so the previous digit cannot ghost.
        dig_sel_d    = (div_cnt_q != '0) ? onehot : 6'b0;
        frame_tick_d = frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt_q     <= '0;
            dig_idx_q     <= 3'd0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            shadow_q      <= '{default: 4'd0};
            seg_q         <= 7'b0;
            dig_sel_q     <= 6'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            dig_idx_q     <= dig_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2.
// Cycle n after a reset release: slot = (n-1)/4 within the frame, the first
// cycle of each slot is dark, a frame is 24 cycles.
module tb_seg_scan_driver;

    logic       clk;
    logic       clr;
    logic [3:0] sec_u, sec_t, min_u, min_t, hour_u, hour_t;
    logic [5:0] blink_mask;
    logic       lz_blank;
    logic [6:0] seg;
    logic [5:0] dig_sel;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Segment patterns for 23:59:58, slots 0..5
    logic [6:0] seg_tab [0:5] = '{7'b1111111, 7'b1101101, 7'b1101111,
                                  7'b1101101, 7'b1001111, 7'b1011011};

    seg_scan_driver #(
        .SCAN_DIV(4), .BLINK_FRAMES(2), .DIV_W(2), .BF_W(1)
    ) dut (
        .clk(clk), .clr(clr),
        .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
        .hour_u(hour_u), .hour_t(hour_t),
        .blink_mask(blink_mask), .lz_blank(lz_blank),
        .seg(seg), .dig_sel(dig_sel), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_2359();
        sec_u = 4'd8; sec_t = 4'd5; min_u = 4'd9; min_t = 4'd5;
        hour_u = 4'd3; hour_t = 4'd2;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks += 3;
            if (seg !== 7'b0) begin n_fail++; $display("FAIL reset_seg cyc=%0d got %b exp 0000000", i, seg); end
            if (dig_sel !== 6'b0) begin n_fail++; $display("FAIL reset_dig_sel cyc=%0d got %b exp 000000", i, dig_sel); end
            if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick cyc=%0d got %b exp 0", i, frame_tick); end
        end
        clr = 1'b0;
    endtask

    // Frame 0: reset shadow, every slot shows 0 even though inputs are 23:59:58.
    task automatic test_first_frame();
        logic [5:0] e_sel;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            e_sel = (((n-1) % 4) == 0) ? 6'b0 : (6'b000001 << ((n-1) / 4));
            n_checks += 3;
            if (dig_sel !== e_sel) begin n_fail++; $display("FAIL first_frame_sel n=%0d got %b exp %b", n, dig_sel, e_sel); end
            if (seg !== 7'b0111111) begin n_fail++; $display("FAIL first_frame_seg n=%0d got %b exp 0111111", n, seg); end
            if (frame_tick !== (n == 24)) begin n_fail++; $display("FAIL first_frame_tick n=%0d got %b exp %b", n, frame_tick, (n == 24)); end
        end
    endtask

    // Frame 1: 23:59:58 decoded; sec_u changes mid-frame and must not show yet.
    // lz_blank=1 here must not blank a non-zero hour tens.
    task automatic test_digit_decode();
        logic [5:0] e_sel;
        int         idx;
        lz_blank = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            idx   = (k-1) / 4;
            e_sel = (((k-1) % 4) == 0) ? 6'b0 : (6'b000001 << idx);
            n_checks += 3;
            if (dig_sel !== e_sel) begin n_fail++; $display("FAIL decode_sel k=%0d got %b exp %b", k, dig_sel, e_sel); end
            if (seg !== seg_tab[idx]) begin n_fail++; $display("FAIL decode_seg k=%0d got %b exp %b", k, seg, seg_tab[idx]); end
            if (frame_tick !== (k == 24)) begin n_fail++; $display("FAIL decode_tick k=%0d got %b exp %b", k, frame_tick, (k == 24)); end
            if (k == 1) sec_u = 4'd9;
        end
    endtask

    // Frame 2: new sec_u is now visible; hour inputs change mid-frame to 07
    // but the displayed hours stay 23 until the next wrap.
    task automatic test_no_tearing();
        logic [6:0] e_seg;
        int         idx;
        lz_blank = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            idx   = (k-1) / 4;
            e_seg = (idx == 0) ? 7'b1101111 : seg_tab[idx];
            n_checks += 2;
            if (seg !== e_seg) begin n_fail++; $display("FAIL no_tear_seg k=%0d got %b exp %b", k, seg, e_seg); end
            if (frame_tick !== (k == 24)) begin n_fail++; $display("FAIL no_tear_tick k=%0d got %b exp %b", k, frame_tick, (k == 24)); end
            if (k == 1) begin hour_t = 4'd0; hour_u = 4'd7; lz_blank = 1'b1; end
        end
    endtask

    // Frame 3: hours 07 with lz_blank=1 -> slot 5 dark but still enabled.
    // Frame 4: lz_blank=0 -> slot 5 shows 0.
    task automatic test_leading_zero();
        logic [6:0] e_seg;
        logic [5:0] e_sel;
        int         idx;
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k <= 24; k++) begin
                @(posedge clk); #1;
                idx   = (k-1) / 4;
                e_sel = (((k-1) % 4) == 0) ? 6'b0 : (6'b000001 << idx);
                case (idx)
                    0:       e_seg = 7'b1101111;
                    4:       e_seg = 7'b0000111;
                    5:       e_seg = (f == 0) ? 7'b0 : 7'b0111111;
                    default: e_seg = seg_tab[idx];
                endcase
                n_checks += 2;
                if (seg !== e_seg) begin n_fail++; $display("FAIL lz_seg f=%0d k=%0d got %b exp %b", f, k, seg, e_seg); end
                if (dig_sel !== e_sel) begin n_fail++; $display("FAIL lz_sel f=%0d k=%0d got %b exp %b", f, k, dig_sel, e_sel); end
            end
            lz_blank = 1'b0;
        end
    endtask

    // Fresh reset, mask=000011: slots 0-1 dark in frames 2-3 only.
    task automatic test_blink();
        logic [6:0] e_seg;
        int         f, k, idx;
        set_2359();
        lz_blank   = 1'b0;
        blink_mask = 6'b000011;
        clr = 1'b1;
        @(posedge clk); #1;
        n_checks += 1;
        if (seg !== 7'b0) begin n_fail++; $display("FAIL blink_reset_seg got %b exp 0000000", seg); end
        clr = 1'b0;
        for (int n = 1; n <= 144; n++) begin
            @(posedge clk); #1;
            f   = (n-1) / 24;
            k   = (n-1) % 24 + 1;
            idx = (k-1) / 4;
            if ((f == 2 || f == 3) && idx < 2) e_seg = 7'b0;
            else if (f == 0)                   e_seg = 7'b0111111;
            else                               e_seg = seg_tab[idx];
            n_checks += 1;
            if (seg !== e_seg) begin n_fail++; $display("FAIL blink_seg n=%0d frame=%0d got %b exp %b", n, f, seg, e_seg); end
        end
        blink_mask = 6'b0;
    endtask

    // Invalid BCD shows a dash; clr mid-slot 3 clears outputs and restarts
    // scanning at slot 0 with a zero shadow.
    task automatic test_invalid_and_clr();
        logic [5:0] e_sel;
        set_2359();
        sec_t = 4'hC;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int n = 1; n <= 38; n++) begin
            @(posedge clk); #1;
            if (n >= 29 && n <= 32) begin
                n_checks += 1;
                if (seg !== 7'b1000000) begin n_fail++; $display("FAIL invalid_seg n=%0d got %b exp 1000000", n, seg); end
            end
            if (n == 38) begin
                n_checks += 1;
                if (dig_sel !== 6'b001000) begin n_fail++; $display("FAIL pre_clr_sel got %b exp 001000", dig_sel); end
            end
        end
        clr = 1'b1;
        @(posedge clk); #1;
        n_checks += 3;
        if (seg !== 7'b0) begin n_fail++; $display("FAIL midclr_seg got %b exp 0000000", seg); end
        if (dig_sel !== 6'b0) begin n_fail++; $display("FAIL midclr_sel got %b exp 000000", dig_sel); end
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL midclr_tick got %b exp 0", frame_tick); end
        clr = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            e_sel = (((n-1) % 4) == 0) ? 6'b0 : (6'b000001 << ((n-1) / 4));
            n_checks += 2;
            if (dig_sel !== e_sel) begin n_fail++; $display("FAIL restart_sel n=%0d got %b exp %b", n, dig_sel, e_sel); end
            if (seg !== 7'b0111111) begin n_fail++; $display("FAIL restart_seg n=%0d got %b exp 0111111", n, seg); end
        end
    endtask

    initial begin
        clr        = 1'b1;
        blink_mask = 6'b0;
        lz_blank   = 1'b0;
        set_2359();
        test_reset();
        test_first_frame();
        test_digit_decode();
        test_no_tearing();
        test_leading_zero();
        test_blink();
        test_invalid_and_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
